tri_fetch: RTL and testbench
============================

Name: tri_fetch

Overview:
Downstream consumer of the HPS SDRAM read bridge. It issues block read requests on the sdr_* bridge signals, captures each 2048-bit read block, and slices it into 288-bit triangle records (9 x 32-bit words). Records are presented one at a time to the intersector over a valid/ready handshake. It repeats until the requested triangle count is exhausted, then reports done to the raytrace control (start_rt/end_rt) logic.

Parameters:
WORD_W, 32, bits per SDRAM word
TRI_WORDS, 9, words per triangle record (3 vertices x 3 coords)
BLOCK_BITS, 2048, width of sdr_readdata
TRIS_PER_BLOCK, 7, triangles per block (floor(2048/288)); bits [2047:2016] unused
CNT_W, 16, width of triangle count/index

Ports:
sdr_clk  in  1  clock
sdr_reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begin a fetch run
tri_base  in  32  byte address of triangle 0; sampled on start
num_tris  in  CNT_W  triangles to fetch; sampled on start
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  level; high from run completion until the next accepted start
sdr_baseaddr  out  32  byte address of the current block request
sdr_nelems  out  30  32-bit words requested for the current block
sdr_readstart  out  1  one-cycle request pulse
sdr_readend  in  1  bridge completion level
sdr_readdata  in  2048  block data; word w at bits [32w +: 32]
tri_valid  out  1  record available
tri_ready  in  1  consumer accepts the record when valid & ready
tri_data  out  288  record; word 0 at bits [31:0]
tri_idx  out  CNT_W  global index of the presented record
tri_last  out  1  presented record is the final one of the run

Behaviour:
- Reset is async active-high and may arrive mid-run. On reset: state IDLE; all outputs 0; sdr_baseaddr = 0; sdr_nelems = 0. All outputs are registered.
- States: IDLE, REQ, WAIT, EMIT, DONE.
- IDLE/DONE + start:
  - num_tris == 0: go to DONE; done = 1 next cycle; no read is issued.
  - otherwise: latch the base address and count, clear done, set busy, go to REQ.
- start is ignored in REQ, WAIT and EMIT.
- REQ (one cycle):
  - sdr_readstart = 1.
  - sdr_baseaddr = base + blk*252 (TRIS_PER_BLOCK*TRI_WORDS*4), using 32-bit wrap-around arithmetic.
  - n = min(remaining, 7); sdr_nelems = n*9.
  - Go to WAIT.
- WAIT:
  - readend_q is a registered copy of sdr_readend.
  - Capture sdr_readdata into the block register on the first cycle where sdr_readend & ~readend_q (rising edge). A level left high from an earlier transfer does not count.
  - On capture: go to EMIT with slot = 0.
  - WAIT has no timeout.
- EMIT:
  - tri_valid = 1; tri_data = blk_reg[288*slot +: 288]; tri_idx = running count; tri_last = (tri_idx == num_tris-1).
  - tri_data, tri_idx and tri_last stay stable while valid & ~ready.
  - On valid & ready: increment slot and tri_idx, decrement remaining.
    - If remaining becomes 0: go to DONE. tri_valid drops next cycle; done = 1 and busy = 0.
    - Else if slot == n-1: go to REQ with blk + 1.
    - Else: present the next slot on the next cycle.
- Throughput: one record per cycle when ready is held high, except at block boundaries.
- Latency: start at cycle T gives readstart at T+1. A readend edge at cycle E gives tri_valid at E+2 (one cycle edge-detect, one cycle capture).
- Capture writes only the block register; sdr_readdata is not used after capture.

Decomposition:
- tri_pkg: WORD_W, TRI_WORDS, TRIS_PER_BLOCK, BLOCK_STRIDE_BYTES = 252, typedef tri_t (logic [287:0]), state enum fetch_state_e.
- One sub-module, tri_slicer: a combinational 7:1 mux from the 2048-bit block register and slot index to tri_t. The FSM, counters and handshake stay in tri_fetch.

Test Plan:
- Single partial block: start, tri_base = 0x1000, num_tris = 3 -> one readstart with baseaddr 0x1000 and nelems 27. Bench raises readend with word w = w. Three records with word0 = 0, 9, 18; tri_last only on idx 2; done = 1.
- Multi-block: num_tris = 10, ready always 1 -> requests (0x1000, 63) then (0x10FC, 27). 10 records, idx 0..9, back-to-back within each block.
- Backpressure: ready toggled 1,0,0,1 -> tri_data and tri_idx held across the 0 cycles; no record skipped or duplicated.
- Stale readend: readend held high before start -> no capture until it falls and rises again; readstart is still pulsed exactly once.
- Zero count and ignored start: num_tris = 0 -> done next cycle, no readstart. A start pulse during EMIT -> ignored; base and count unchanged.
- Reset mid-run: assert sdr_reset during WAIT and again during EMIT -> all outputs 0 immediately. A subsequent start(0x2000, 1) -> baseaddr 0x2000, nelems 9.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle fetch path.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package tri_pkg;

  localparam int WORD_W         = 32;
  localparam int TRI_WORDS      = 9;
  localparam int TRI_BITS       = WORD_W * TRI_WORDS;
  localparam int BLOCK_BITS     = 2048;
  localparam int TRIS_PER_BLOCK = 7;
  localparam int CNT_W          = 16;

  // Byte distance between consecutive block requests (7 records of 9 words).
  localparam logic [31:0] BLOCK_STRIDE_BYTES = 32'd252;

  typedef logic [TRI_BITS-1:0] tri_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } fetch_state_e;

  // Number of records carried by the next block: min(remaining, 7).
  function automatic logic [2:0] blk_tris(input logic [CNT_W-1:0] remaining);
    if (remaining >= CNT_W'(TRIS_PER_BLOCK))
      blk_tris = 3'(TRIS_PER_BLOCK);
    else
      blk_tris = remaining[2:0];
  endfunction

  // Word count requested from the bridge for the next block.
  function automatic logic [29:0] blk_nelems(input logic [CNT_W-1:0] remaining);
    blk_nelems = 30'(blk_tris(remaining)) * 30'(TRI_WORDS);
  endfunction

endpackage

// File: rtl/tri_slicer.sv
// Selects one 288-bit triangle record out of a captured 2048-bit block.
// Latency: purely combinational.
// Backpressure: none; the caller holds slot/block stable as needed.
module tri_slicer
  import tri_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] blk,
  input  logic [2:0]            slot,
  output tri_t                  rec
);

  // The top 32 bits of a block never hold a whole record and are dropped.
  logic unused_tail;
  assign unused_tail = ^blk[BLOCK_BITS-1:TRIS_PER_BLOCK*TRI_BITS];

  // 7:1 record mux; out-of-range slot values yield zero.
  always_comb begin
    rec = '0;
    for (int i = 0; i < TRIS_PER_BLOCK; i++) begin
      if (slot == 3'(i))
        rec = blk[TRI_BITS*i +: TRI_BITS];
    end
  end

endmodule

// File: rtl/tri_fetch.sv
// Fetches triangle blocks over the SDRAM read bridge and streams 288-bit records.
// Latency: start -> readstart 1 cycle; readend rising edge -> tri_valid 2 cycles.
// Backpressure: tri_valid/tri_ready; record outputs held stable while stalled.
module tri_fetch
  import tri_pkg::*;
(
  input  logic                  sdr_clk,
  input  logic                  sdr_reset,
  input  logic                  start,
  input  logic [31:0]           tri_base,
  input  logic [CNT_W-1:0]      num_tris,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           sdr_baseaddr,
  output logic [29:0]           sdr_nelems,
  output logic                  sdr_readstart,
  input  logic                  sdr_readend,
  input  logic [BLOCK_BITS-1:0] sdr_readdata,
  output logic                  tri_valid,
  input  logic                  tri_ready,
  output tri_t                  tri_data,
  output logic [CNT_W-1:0]      tri_idx,
  output logic                  tri_last
);

  fetch_state_e          state;
  logic [CNT_W-1:0]      remaining;
  logic [CNT_W-1:0]      rem_next;
  logic [2:0]            n_blk;
  logic [2:0]            slot;
  logic [2:0]            slice_sel;
  logic [BLOCK_BITS-1:0] blk_reg;
  logic                  readend_q;
  tri_t                  slice_dat;

  assign rem_next = remaining - CNT_W'(1);

  // While a record is shown, the mux looks one slot ahead so the next record
  // can be loaded on the accepting edge; otherwise it points at slot itself.
  assign slice_sel = tri_valid ? 3'(slot + 3'd1) : slot;

  tri_slicer u_slicer (
    .blk  (blk_reg),
    .slot (slice_sel),
    .rec  (slice_dat)
  );

  // Delayed copy of readend so that only a fresh rising edge triggers capture.
  always_ff @(posedge sdr_clk or posedge sdr_reset) begin
    if (sdr_reset)
      readend_q <= 1'b0;
    else
      readend_q <= sdr_readend;
  end

  // Fetch FSM: request issue, block capture, record handshake and run status.
  always_ff @(posedge sdr_clk or posedge sdr_reset) begin
    if (sdr_reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      sdr_baseaddr  <= '0;
      sdr_nelems    <= '0;
      sdr_readstart <= 1'b0;
      tri_valid     <= 1'b0;
      tri_data      <= '0;
      tri_idx       <= '0;
      tri_last      <= 1'b0;
      remaining     <= '0;
      n_blk         <= '0;
      slot          <= '0;
      blk_reg       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (num_tris == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              // First request goes out on the same edge that leaves IDLE/DONE.
              state         <= ST_REQ;
              done          <= 1'b0;
              busy          <= 1'b1;
              remaining     <= num_tris;
              tri_idx       <= '0;
              n_blk         <= blk_tris(num_tris);
              sdr_baseaddr  <= tri_base;
              sdr_nelems    <= blk_nelems(num_tris);
              sdr_readstart <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          sdr_readstart <= 1'b0;
          state         <= ST_WAIT;
        end

        ST_WAIT: begin
          if (sdr_readend && !readend_q) begin
            blk_reg <= sdr_readdata;
            slot    <= '0;
            state   <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (!tri_valid) begin
            // First record of a freshly captured block.
            tri_valid <= 1'b1;
            tri_data  <= slice_dat;
            tri_last  <= (remaining == CNT_W'(1));
          end else if (tri_ready) begin
            tri_idx   <= tri_idx + CNT_W'(1);
            remaining <= rem_next;
            if (rem_next == '0) begin
              state     <= ST_DONE;
              tri_valid <= 1'b0;
              tri_last  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else if (slot == 3'(n_blk - 3'd1)) begin
              // Block exhausted: next request is one stride further on.
              state         <= ST_REQ;
              tri_valid     <= 1'b0;
              tri_last      <= 1'b0;
              slot          <= '0;
              n_blk         <= blk_tris(rem_next);
              sdr_baseaddr  <= sdr_baseaddr + BLOCK_STRIDE_BYTES;
              sdr_nelems    <= blk_nelems(rem_next);
              sdr_readstart <= 1'b1;
            end else begin
              slot     <= 3'(slot + 3'd1);
              tri_data <= slice_dat;
              tri_last <= (rem_next == CNT_W'(1));
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fetch.sv
// Scoreboard bench for tri_fetch with a small bridge model and a throttled consumer.
// Latency: checks readstart one cycle after start and tri_valid two cycles after readend.
// Backpressure: consumer ready is either held high or toggled 1,0,0,1.
module tb_tri_fetch;
  import tri_pkg::*;

  logic                  sdr_clk = 1'b0;
  logic                  sdr_reset;
  logic                  start;
  logic [31:0]           tri_base;
  logic [CNT_W-1:0]      num_tris;
  logic                  busy;
  logic                  done;
  logic [31:0]           sdr_baseaddr;
  logic [29:0]           sdr_nelems;
  logic                  sdr_readstart;
  logic                  sdr_readend;
  logic [BLOCK_BITS-1:0] sdr_readdata;
  logic                  tri_valid;
  logic                  tri_ready;
  tri_t                  tri_data;
  logic [CNT_W-1:0]      tri_idx;
  logic                  tri_last;

  always #5 sdr_clk = ~sdr_clk;

  tri_fetch dut (
    .sdr_clk       (sdr_clk),
    .sdr_reset     (sdr_reset),
    .start         (start),
    .tri_base      (tri_base),
    .num_tris      (num_tris),
    .busy          (busy),
    .done          (done),
    .sdr_baseaddr  (sdr_baseaddr),
    .sdr_nelems    (sdr_nelems),
    .sdr_readstart (sdr_readstart),
    .sdr_readend   (sdr_readend),
    .sdr_readdata  (sdr_readdata),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .tri_data      (tri_data),
    .tri_idx       (tri_idx),
    .tri_last      (tri_last)
  );

  typedef struct {
    logic [31:0] addr;
    logic [29:0] nelems;
  } req_t;

  typedef struct {
    tri_t dat;
    int   idx;
    logic last;
    int   slot;
  } rec_t;

  req_t req_q[$];
  rec_t rec_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   blk_tag  = 0;

  task automatic check(input string tag, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Word w of a block tagged 'tag' carries (tag << 16) | w.
  function automatic logic [31:0] wval(input int tag, input int w);
    return (32'(tag) << 16) | 32'(w);
  endfunction

  task automatic drive_block(input int tag);
    for (int w = 0; w < 64; w++)
      sdr_readdata[32*w +: 32] = wval(tag, w);
  endtask

  task automatic chk_zero();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rs", sdr_readstart, 0);
    check("rst_addr", sdr_baseaddr, 0);
    check("rst_nelems", sdr_nelems, 0);
    check("rst_vld", tri_valid, 0);
    check("rst_dat", tri_data, 0);
    check("rst_idx", tri_idx, 0);
    check("rst_last", tri_last, 0);
  endtask

  task automatic run_fetch(input logic [31:0] base, input int num, input bit bp,
                           input bit stale, input bit inject);
    req_t             rq;
    rec_t             r;
    int               tag0, cyc, resp_cnt, raise_cyc, last_acc, rem;
    bit               await_vld, prev_stall, injected;
    tri_t             held_dat;
    logic [CNT_W-1:0] held_idx;
    logic [3:0]       rdy_pat;

    rdy_pat    = 4'b1001;
    tag0       = blk_tag;
    resp_cnt   = 0;
    raise_cyc  = 0;
    last_acc   = -10;
    await_vld  = 0;
    prev_stall = 0;
    injected   = 0;
    held_dat   = '0;
    held_idx   = '0;

    for (int b = 0; b < (num + 6) / 7; b++) begin
      rem       = num - 7 * b;
      rq.addr   = base + 32'(b * 252);
      rq.nelems = 30'(((rem > 7) ? 7 : rem) * 9);
      req_q.push_back(rq);
    end
    for (int i = 0; i < num; i++) begin
      r.slot = i % 7;
      r.idx  = i;
      r.last = (i == num - 1);
      for (int k = 0; k < 9; k++)
        r.dat[32*k +: 32] = wval(tag0 + i / 7, r.slot * 9 + k);
      rec_q.push_back(r);
    end

    if (stale) begin
      drive_block(16'hEE);
      sdr_readend = 1'b1;
      repeat (3) @(negedge sdr_clk);
    end

    @(negedge sdr_clk);
    start     = 1'b1;
    tri_base  = base;
    num_tris  = CNT_W'(num);
    tri_ready = 1'b0;
    @(negedge sdr_clk);
    start = 1'b0;
    check("rs_latency", sdr_readstart, 1);
    check("done_clr", done, 0);

    cyc = 0;
    while (!done && cyc < 3000) begin
      start = 1'b0;
      check("busy_run", busy, 1);

      // bridge model
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 1) sdr_readend = 1'b0;
        if (resp_cnt == 0) begin
          drive_block(blk_tag);
          blk_tag++;
          sdr_readend = 1'b1;
          raise_cyc   = cyc;
          await_vld   = 1;
        end
      end
      if (sdr_readstart) begin
        check("req_extra", req_q.size() > 0, 1);
        if (req_q.size() > 0) begin
          rq = req_q.pop_front();
          check("req_addr", sdr_baseaddr, rq.addr);
          check("req_nelems", sdr_nelems, rq.nelems);
        end
        resp_cnt = stale ? 6 : 3;
        if (!stale) sdr_readend = 1'b0;
      end
      if (resp_cnt > 0) check("no_vld_wait", tri_valid, 0);
      if (await_vld && tri_valid) begin
        check("vld_latency", cyc - raise_cyc, 2);
        await_vld = 0;
        drive_block(16'hBAD);
      end

      // consumer
      if (inject && tri_valid && !injected) begin
        start    = 1'b1;
        tri_base = 32'hDEAD_0000;
        num_tris = 16'd1;
        injected = 1;
      end
      if (prev_stall) begin
        check("hold_vld", tri_valid, 1);
        check("hold_dat", tri_data, held_dat);
        check("hold_idx", tri_idx, held_idx);
      end
      tri_ready = bp ? rdy_pat[cyc % 4] : 1'b1;
      if (tri_valid && tri_ready) begin
        check("rec_extra", rec_q.size() > 0, 1);
        if (rec_q.size() > 0) begin
          r = rec_q.pop_front();
          check("rec_dat", tri_data, r.dat);
          check("rec_idx", tri_idx, r.idx);
          check("rec_last", tri_last, r.last);
          if (!bp && r.slot != 0) check("b2b", cyc - last_acc, 1);
          last_acc = cyc;
        end
      end
      prev_stall = tri_valid && !tri_ready;
      held_dat   = tri_data;
      held_idx   = tri_idx;

      @(negedge sdr_clk);
      cyc++;
    end
    start     = 1'b0;
    tri_ready = 1'b0;
    check("run_done", done, 1);
    check("busy_off", busy, 0);
    check("vld_off", tri_valid, 0);
    check("recs_left", rec_q.size(), 0);
    check("reqs_left", req_q.size(), 0);
    rec_q.delete();
    req_q.delete();
  endtask

  initial begin
    int w;
    sdr_reset    = 1'b1;
    start        = 1'b0;
    tri_base     = '0;
    num_tris     = '0;
    sdr_readend  = 1'b0;
    sdr_readdata = '0;
    tri_ready    = 1'b0;
    #1;
    chk_zero();
    repeat (2) @(negedge sdr_clk);
    sdr_reset = 1'b0;

    run_fetch(32'h0000_1000, 3, 0, 0, 0);   // single partial block
    run_fetch(32'h0000_1000, 10, 0, 0, 1);  // two blocks, start during EMIT ignored
    run_fetch(32'h0000_1000, 10, 1, 0, 0);  // backpressure 1,0,0,1
    run_fetch(32'hFFFF_FF80, 9, 1, 1, 0);   // stale readend, address wrap

    // reset while waiting for the block
    sdr_readend = 1'b0;
    @(negedge sdr_clk);
    start    = 1'b1;
    tri_base = 32'h0000_3000;
    num_tris = 16'd20;
    @(negedge sdr_clk);
    start = 1'b0;
    check("rw_rs", sdr_readstart, 1);
    repeat (2) @(negedge sdr_clk);
    check("rw_busy", busy, 1);
    sdr_reset = 1'b1;
    #1;
    chk_zero();
    @(negedge sdr_clk);
    sdr_reset = 1'b0;

    // reset while a record is presented
    @(negedge sdr_clk);
    start    = 1'b1;
    tri_base = 32'h0000_3000;
    num_tris = 16'd20;
    @(negedge sdr_clk);
    start = 1'b0;
    @(negedge sdr_clk);
    drive_block(16'h77);
    sdr_readend = 1'b1;
    w = 0;
    while (!tri_valid && w < 10) begin
      @(negedge sdr_clk);
      w++;
    end
    check("re_vld", tri_valid, 1);
    check("re_dat0", tri_data[31:0], wval(16'h77, 0));
    sdr_reset = 1'b1;
    #1;
    chk_zero();
    @(negedge sdr_clk);
    sdr_reset   = 1'b0;
    sdr_readend = 1'b0;

    // zero-length run
    @(negedge sdr_clk);
    check("zc_done0", done, 0);
    start    = 1'b1;
    tri_base = 32'h0000_4000;
    num_tris = 16'd0;
    @(negedge sdr_clk);
    start = 1'b0;
    check("zc_done", done, 1);
    check("zc_busy", busy, 0);
    check("zc_rs", sdr_readstart, 0);
    repeat (3) begin
      @(negedge sdr_clk);
      check("zc_no_rs", sdr_readstart, 0);
    end

    run_fetch(32'h0000_2000, 1, 0, 0, 0);   // clean run after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
